// File: rtl/sys_output_scanner.sv
// sys_output_scanner: sweeps SYS_output_sel through every debug view of
// `system`, lets SYS_leds settle, captures each view and hands it to a
// board-side consumer as a valid/ready word stream.
module sys_output_scanner #(
  parameter int SEL_COUNT     = 8,   // views swept: 0..SEL_COUNT-1 (1..8)
  parameter int SETTLE_CYCLES = 2,   // cycles select is held before sampling (1..15)
  parameter int DATA_W        = 27
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              SCN_start,
  input  logic              SCN_continuous,
  output logic [7:0]        SYS_output_sel,
  input  logic [DATA_W-1:0] SYS_leds,
  output logic              SCN_valid,
  input  logic              SCN_ready,
  output logic [2:0]        SCN_sel,
  output logic [DATA_W-1:0] SCN_data,
  output logic              SCN_busy,
  output logic              SCN_done
);

  localparam logic [2:0] SEL_LAST = 3'(SEL_COUNT - 1);
  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [2:0]          sel, sel_n;
  logic [3:0]          cnt, cnt_n;
  logic                valid_n;
  logic [2:0]          scn_sel_n;
  logic [DATA_W-1:0]   data_n;
  logic                done_n;

  // The select into `system` is just the current view index; upper bits unused.
  assign SYS_output_sel = {5'b0, sel};
  assign SCN_busy       = (state != IDLE);

  // State and all stream outputs are registered, so SCN_ready never reaches
  // an output combinationally.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state     <= IDLE;
      sel       <= 3'd0;
      cnt       <= 4'd0;
      SCN_valid <= 1'b0;
      SCN_sel   <= 3'd0;
      SCN_data  <= '0;
      SCN_done  <= 1'b0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      cnt       <= cnt_n;
      SCN_valid <= valid_n;
      SCN_sel   <= scn_sel_n;
      SCN_data  <= data_n;
      SCN_done  <= done_n;
    end
  end

  // Next-state logic: hold everything by default, done is a pulse.
  always_comb begin
    state_n   = state;
    sel_n     = sel;
    cnt_n     = cnt;
    valid_n   = SCN_valid;
    scn_sel_n = SCN_sel;
    data_n    = SCN_data;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (SCN_start) begin
          sel_n   = 3'd0;
          cnt_n   = 4'd0;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        // Capture on the SETTLE_CYCLES-th edge after the select changed.
        if (cnt == CNT_LAST) begin
          data_n    = SYS_leds;
          scn_sel_n = sel;
          valid_n   = 1'b1;
          state_n   = PRESENT;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      PRESENT: begin
        if (SCN_valid && SCN_ready) begin
          valid_n = 1'b0;
          cnt_n   = 4'd0;
          if (sel == SEL_LAST) begin
            done_n = 1'b1;
            // Continuous mode is only looked at here, at the end of a sweep.
            if (SCN_continuous) begin
              sel_n   = 3'd0;
              state_n = SETTLE;
            end else begin
              state_n = IDLE;
            end
          end else begin
            sel_n   = sel + 3'd1;
            state_n = SETTLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sys_output_scanner.sv
// Testbench for sys_output_scanner: directed scenarios drive the stream, a
// scoreboard queue per instance holds the expected words, and negedge monitors
// pop and compare on every handshake.
module tb_sys_output_scanner;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Default-parameter instance
  logic        rst, start, cont, ready;
  logic [7:0]  osel;
  logic [26:0] leds;
  logic        valid, busy, done;
  logic [2:0]  scn_sel;
  logic [26:0] data;

  assign leds = {osel[2:0], 24'hA5A5A5};

  sys_output_scanner dut (
    .SYS_clk(clk), .SYS_reset(rst), .SCN_start(start), .SCN_continuous(cont),
    .SYS_output_sel(osel), .SYS_leds(leds), .SCN_valid(valid), .SCN_ready(ready),
    .SCN_sel(scn_sel), .SCN_data(data), .SCN_busy(busy), .SCN_done(done)
  );

  // SEL_COUNT=3, SETTLE_CYCLES=4 instance with leds changing every cycle
  logic        start2, cont2, ready2;
  logic [7:0]  osel2;
  logic [26:0] leds2;
  logic        valid2, busy2, done2;
  logic [2:0]  scn_sel2;
  logic [26:0] data2;

  assign leds2 = cyc[26:0];

  sys_output_scanner #(.SEL_COUNT(3), .SETTLE_CYCLES(4), .DATA_W(27)) dut2 (
    .SYS_clk(clk), .SYS_reset(rst), .SCN_start(start2), .SCN_continuous(cont2),
    .SYS_output_sel(osel2), .SYS_leds(leds2), .SCN_valid(valid2), .SCN_ready(ready2),
    .SCN_sel(scn_sel2), .SCN_data(data2), .SCN_busy(busy2), .SCN_done(done2)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [26:0] data;
  } word_t;

  word_t       q1[$];
  word_t       q2[$];
  int unsigned hs2[$];
  int          done_cnt1 = 0;
  int          done_cnt2 = 0;
  int          total = 0;
  int          passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor for the default instance
  always @(negedge clk) begin : mon1
    word_t w;
    if (valid && ready) begin
      if (q1.size() == 0) begin
        total++;
        $display("FAIL sb1_extra_word: got sel %0d data %0h, expected no word", scn_sel, data);
      end else begin
        w = q1.pop_front();
        check("sb1_sel", 32'(scn_sel), 32'(w.sel));
        check("sb1_data", 32'(data), 32'(w.data));
      end
    end
    if (done) done_cnt1++;
  end

  // Monitor for the small instance
  always @(negedge clk) begin : mon2
    word_t w;
    if (valid2 && ready2) begin
      hs2.push_back(cyc);
      if (q2.size() == 0) begin
        total++;
        $display("FAIL sb2_extra_word: got sel %0d data %0h, expected no word", scn_sel2, data2);
      end else begin
        w = q2.pop_front();
        check("sb2_sel", 32'(scn_sel2), 32'(w.sel));
        check("sb2_data", 32'(data2), 32'(w.data));
      end
    end
    if (done2) done_cnt2++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_sweep(input int n);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.sel  = 3'(i);
      w.data = {3'(i), 24'hA5A5A5};
      q1.push_back(w);
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_vs(input logic [2:0] s, input string name);
    int n = 0;
    @(negedge clk);
    while (!(valid && scn_sel == s) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(valid && scn_sel == s), 32'd1);
  endtask

  task automatic wait_done1(input string name);
    int n = 0;
    @(negedge clk);
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(done), 32'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int unsigned c0;
    word_t       w;
    rst = 1'b1; start = 1'b0; cont = 1'b0; ready = 1'b0;
    start2 = 1'b0; cont2 = 1'b0; ready2 = 1'b1;

    // Reset state
    tick();
    @(negedge clk);
    check("rst_osel", 32'(osel), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_sel", 32'(scn_sel), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst2_valid", 32'(valid2), 32'd0);
    check("rst2_data", 32'(data2), 32'd0);
    check("rst2_busy", 32'(busy2), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single sweep, ready high: valid on k%3==2 after start edge, done at k=24
    push_sweep(8);
    done_cnt1 = 0;
    ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      check("s1_valid", 32'(valid), 32'((k % 3) == 2));
      check("s1_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    check("s1_done", 32'(done), 32'd1);
    check("s1_busy_end", 32'(busy), 32'd0);
    check("s1_valid_end", 32'(valid), 32'd0);
    @(negedge clk);
    check("s1_done_pulse", 32'(done), 32'd0);
    check("s1_q_empty", 32'(q1.size()), 32'd0);
    check("s1_done_cnt", 32'(done_cnt1), 32'd1);

    // Backpressure at word 3
    tick();
    push_sweep(8);
    done_cnt1 = 0;
    ready = 1'b1;
    pulse_start();
    wait_vs(3'd2, "s2_word2");
    tick();
    ready = 1'b0;
    wait_vs(3'd3, "s2_word3");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("s2_hold_valid", 32'(valid), 32'd1);
      check("s2_hold_sel", 32'(scn_sel), 32'd3);
      check("s2_hold_osel", 32'(osel), 32'd3);
      check("s2_hold_data", 32'(data), 32'({3'd3, 24'hA5A5A5}));
    end
    tick();
    ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("s2_gap0", 32'(valid), 32'd0);
    @(negedge clk);
    check("s2_gap1", 32'(valid), 32'd0);
    @(negedge clk);
    check("s2_word4_valid", 32'(valid), 32'd1);
    check("s2_word4_sel", 32'(scn_sel), 32'd4);
    wait_done1("s2_done");
    @(negedge clk);
    check("s2_q_empty", 32'(q1.size()), 32'd0);
    check("s2_done_cnt", 32'(done_cnt1), 32'd1);

    // Continuous mode: two back-to-back restarts, then a final sweep
    tick();
    push_sweep(8); push_sweep(8); push_sweep(8);
    done_cnt1 = 0;
    cont = 1'b1;
    ready = 1'b1;
    pulse_start();
    for (int sw = 0; sw < 2; sw++) begin
      wait_done1("s3_done");
      check("s3_busy_at_done", 32'(busy), 32'd1);
      check("s3_valid_at_done", 32'(valid), 32'd0);
      @(negedge clk);
      @(negedge clk);
      check("s3_restart_valid", 32'(valid), 32'd1);
      check("s3_restart_sel", 32'(scn_sel), 32'd0);
    end
    tick();
    cont = 1'b0;
    wait_done1("s3_final_done");
    check("s3_final_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("s3_idle_busy", 32'(busy), 32'd0);
    check("s3_q_empty", 32'(q1.size()), 32'd0);
    check("s3_done_cnt", 32'(done_cnt1), 32'd3);

    // Start pulsed while busy is ignored
    tick();
    push_sweep(8);
    done_cnt1 = 0;
    ready = 1'b1;
    pulse_start();
    wait_vs(3'd4, "s4_word4");
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done1("s4_done");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s4_idle_busy", 32'(busy), 32'd0);
      check("s4_idle_valid", 32'(valid), 32'd0);
    end
    check("s4_q_empty", 32'(q1.size()), 32'd0);
    check("s4_done_cnt", 32'(done_cnt1), 32'd1);

    // Reset while presenting sel=5
    tick();
    push_sweep(5);
    done_cnt1 = 0;
    ready = 1'b1;
    pulse_start();
    wait_vs(3'd4, "s5_word4");
    tick();
    ready = 1'b0;
    wait_vs(3'd5, "s5_word5");
    check("s5_osel5", 32'(osel), 32'd5);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("s5_rst_valid", 32'(valid), 32'd0);
    check("s5_rst_osel", 32'(osel), 32'd0);
    check("s5_rst_busy", 32'(busy), 32'd0);
    check("s5_rst_sel", 32'(scn_sel), 32'd0);
    check("s5_rst_data", 32'(data), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("s5_no_done", 32'(done), 32'd0);
    end
    check("s5_q_empty", 32'(q1.size()), 32'd0);
    check("s5_done_cnt", 32'(done_cnt1), 32'd0);
    tick();
    push_sweep(8);
    ready = 1'b1;
    pulse_start();
    wait_done1("s5_clean_done");
    @(negedge clk);
    check("s5_clean_q_empty", 32'(q1.size()), 32'd0);
    check("s5_clean_done_cnt", 32'(done_cnt1), 32'd1);

    // SEL_COUNT=3, SETTLE_CYCLES=4: word i = leds at start edge + 4 + 5*i
    tick();
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      w.sel  = 3'(i);
      w.data = 27'(c0 + 4 + 5 * i);
      q2.push_back(w);
    end
    hs2.delete();
    done_cnt2 = 0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    begin
      int n = 0;
      @(negedge clk);
      while (!done2 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    check("s6_done", 32'(done2), 32'd1);
    check("s6_done_time", cyc, c0 + 16);
    check("s6_busy_end", 32'(busy2), 32'd0);
    @(negedge clk);
    check("s6_q_empty", 32'(q2.size()), 32'd0);
    check("s6_done_cnt", 32'(done_cnt2), 32'd1);
    check("s6_hs_count", 32'(hs2.size()), 32'd3);
    if (hs2.size() == 3) begin
      check("s6_space01", hs2[1] - hs2[0], 32'd5);
      check("s6_space12", hs2[2] - hs2[1], 32'd5);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sys_output_scanner.md
# sys_output_scanner

Downstream companion to `system`. It sweeps `SYS_output_sel` through every debug view, waits for `SYS_leds` to settle, and captures each 27-bit view. Each capture is presented as a valid/ready word stream to the board-side consumer (UART dumper or display driver). This replaces hand-driven `SYS_output_sel` cycling on hardware and in simulation.

## Interface
Parameters:
- `SEL_COUNT`, default 8: number of views swept, selects 0..SEL_COUNT-1; legal range 1..8.
- `SETTLE_CYCLES`, default 2: cycles `SYS_output_sel` is held before `SYS_leds` is sampled; legal range 1..15.
- `DATA_W`, default 27: width of `SYS_leds`.

Ports:
- Clock and reset: one clock, `SYS_clk`; `SYS_reset` is synchronous and active-high.
- `SYS_clk`, in, 1: rising-edge clock shared with `system`.
- `SYS_reset`, in, 1: synchronous, active-high reset.
- `SCN_start`, in, 1: begins a sweep when sampled high in IDLE.
- `SCN_continuous`, in, 1: when high at sweep end, a new sweep starts immediately.
- `SYS_output_sel`, out, 8: select driven into `system`; always {5'b0, sel[2:0]}.
- `SYS_leds`, in, DATA_W: view returned by `system`.
- `SCN_valid`, out, 1: captured word available.
- `SCN_ready`, in, 1: consumer accepts the word.
- `SCN_sel`, out, 3: select the captured word belongs to.
- `SCN_data`, out, DATA_W: captured `SYS_leds`.
- `SCN_busy`, out, 1: high in any state other than IDLE.
- `SCN_done`, out, 1: one-cycle pulse after the last word of a sweep is accepted.

## Operation
States:
- **IDLE**
  - If `SCN_start`=1: sel←0, settle counter←0, go to SETTLE.
- **SETTLE**
  - Counter increments each cycle.
  - When counter = SETTLE_CYCLES-1: `SCN_data`←`SYS_leds`, `SCN_sel`←sel, `SCN_valid`←1, go to PRESENT.
- **PRESENT**
  - Holds `SCN_valid`, `SCN_data`, `SCN_sel` and `SYS_output_sel` stable until `SCN_valid`&`SCN_ready`.
  - On handshake with sel < SEL_COUNT-1: `SCN_valid`←0, sel←sel+1, counter←0, go to SETTLE.
  - On handshake with sel = SEL_COUNT-1: `SCN_valid`←0, `SCN_done`←1 for one cycle.
    - If `SCN_continuous`=1: sel←0, counter←0, go to SETTLE.
    - Otherwise go to IDLE.

Rules:
- `SCN_start` is ignored while busy; it is not queued.
- `SCN_continuous` is sampled only at the final handshake. Deasserting it mid-sweep lets the current sweep finish, then the block returns to IDLE.
- sel wraps only via the SEL_COUNT-1 → 0 restart path and never exceeds SEL_COUNT-1.
- `SYS_leds` is sampled only on the capture edge; changes at other times have no effect.
- No combinational path from `SCN_ready` to any output.

## Timing
- Reset: on the first edge with `SYS_reset`=1, the block is in IDLE with sel=0 and all outputs as below. `SYS_reset` has priority over every other input.
  - `SYS_output_sel`=0, `SCN_valid`=0, `SCN_sel`=0, `SCN_data`=0, `SCN_busy`=0, `SCN_done`=0.
- Reset mid-sweep: the sweep is aborted with no `SCN_done`. A pending word is dropped.
- Start latency: `SCN_start` sampled at edge E sets `SYS_output_sel`=0 after E. `SCN_valid` rises after edge E+SETTLE_CYCLES, carrying `SYS_leds` sampled at that edge.
- Per-word latency: a handshake at edge H drives the new `SYS_output_sel` after H. The next `SCN_valid` rises after edge H+SETTLE_CYCLES.
- Full sweep with `SCN_ready` tied high: SEL_COUNT·(SETTLE_CYCLES+1) cycles from the start edge to the final handshake.
- `SCN_done`: high for exactly the cycle after the final handshake edge, in both single and continuous modes.
- `SCN_busy` rises after the start edge. It falls after the final handshake edge in single mode and stays high in continuous mode.

## Test plan
- **Single sweep, ready=1, defaults:** bench models `SYS_leds` = {sel, 24'hA5A5A5}; pulse start.
  - Exactly 8 words, `SCN_sel` 0..7, `SCN_data` = {sel, 24'hA5A5A5}.
  - `SCN_valid` first rises 2 cycles after the start edge and then every 3 cycles.
  - `SCN_done` is a single pulse, then `SCN_busy`=0.
- **Backpressure:** `SCN_ready` low for 5 cycles at word 3.
  - `SCN_valid`=1 with `SCN_data`, `SCN_sel`=3 and `SYS_output_sel`=3 all stable for those 5 cycles.
  - Word 4 follows 2 cycles after the handshake.
- **Continuous mode:** `SCN_continuous`=1 for two sweeps, then 0.
  - After each word 7: `SCN_done` pulse, then word 0 with no IDLE cycle.
  - A third sweep completes, then the block returns to IDLE.
- **Start while busy:** pulse `SCN_start` during word 4.
  - No restart; sel sequence is unbroken 0..7; exactly one `SCN_done`.
- **Reset mid-sweep:** assert `SYS_reset` while in PRESENT at sel=5.
  - Next cycle: `SCN_valid`=0, `SYS_output_sel`=0, `SCN_busy`=0, no `SCN_done`.
  - A new start yields a clean sweep from sel 0.
- **Parameters SEL_COUNT=3, SETTLE_CYCLES=4:** `SYS_leds` changes on every cycle.
  - 3 words, each equal to `SYS_leds` at the 4th edge after its select changed.
  - Words spaced 5 cycles apart; `SCN_done` after word 2.
